// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock-enable divider bank.
// Divisor D gives a tick period of D+1 cycles and a div_clk period of 2*(D+1).
package clk_div_pkg;

  localparam int unsigned SYS_CLK_HZ  = 50_000_000;
  localparam int unsigned DIV_REFRESH = 4999;
  localparam int unsigned DIV_BUTTON  = 24_999_999;

  // Divisor whose div_clk output runs at f Hz (tick rate is 2*f)
  function automatic int unsigned div_for_hz(input int unsigned f);
    return SYS_CLK_HZ / (2 * f) - 1;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: wrap counter, active/shadow divisor with pending flag,
// and registered tick strobe and div_clk level.
module clk_div_channel #(
  parameter int               CNT_W   = 26,
  parameter logic [CNT_W-1:0] DIV_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             tick,
  output logic             div_clk,
  output logic             pending
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             tick_q, tick_d;
  logic             div_clk_q, div_clk_d;
  logic             wrap;

  // >= rather than == so a smaller divisor applied while disabled still wraps
  assign wrap = (cnt_q >= div_q);

  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    tick_d    = 1'b0;
    div_clk_d = div_clk_q;
    if (sync) begin
      cnt_d     = '0;
      div_clk_d = 1'b0;
      pending_d = 1'b0;
      if (wr) begin
        div_d    = wr_div;
        shadow_d = wr_div;
      end else if (pending_q) begin
        div_d = shadow_q;
      end
    end else begin
      if (en) begin
        if (wrap) begin
          cnt_d     = '0;
          tick_d    = 1'b1;
          div_clk_d = ~div_clk_q;
          if (pending_q) begin
            div_d     = shadow_q;
            pending_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (pending_q) begin
        div_d     = shadow_q;
        pending_d = 1'b0;
      end
      // A write in a wrap cycle lands in the shadow and waits for the next wrap
      if (wr) begin
        shadow_d  = wr_div;
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      div_q     <= DIV_RST;
      shadow_q  <= DIV_RST;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      div_clk_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      div_clk_q <= div_clk_d;
    end
  end

  assign tick    = tick_q;
  assign div_clk = div_clk_q;
  assign pending = pending_q;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel clock-enable generator: NUM_CH independent dividers sharing a
// single divisor write port and a global phase-sync.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int                      NUM_CH   = 2,
  parameter int                      CNT_W    = 26,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {26'(DIV_BUTTON), 26'(DIV_REFRESH)}
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_CH-1:0]                             en,
  input  logic                                          sync,
  input  logic                                          cfg_valid,
  output logic                                          cfg_ready,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                              cfg_div,
  output logic [NUM_CH-1:0]                             tick,
  output logic [NUM_CH-1:0]                             div_clk
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] wr;
  logic              accept;

  // Out-of-range channel numbers match nothing, so they are accepted and dropped
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = ~pending[i];
      end
    end
  end

  assign accept = cfg_valid && cfg_ready;

  always_comb begin
    wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr[i] = accept && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_INIT[g*CNT_W +: CNT_W])
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[g]),
      .sync    (sync),
      .wr      (wr[g]),
      .wr_div  (cfg_div),
      .tick    (tick[g]),
      .div_clk (div_clk[g]),
      .pending (pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: three channels with small divisors so that
// cfg_ch=3 is a representable out-of-range channel.
module tb_clk_div_bank;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;
  localparam logic [NUM_CH*CNT_W-1:0] DIV_INIT = {8'd5, 8'd3, 8'd1};

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NUM_CH-1:0] en = '0;
  logic              sync = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] div_clk;

  int checks = 0;
  int errors = 0;

  clk_div_bank #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .DIV_INIT (DIV_INIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .tick      (tick),
    .div_clk   (div_clk)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges counted from reset release: ch0 D=1 ticks on even edges, ch1 D=3 every 4th
  task automatic test_reset();
    logic [NUM_CH-1:0] et, ed;
    en = 3'b011;
    #1 rst = 1'b1;
    step();
    checks++;
    if (tick !== 3'b000) begin errors++; $display("[TB] FAIL reset_tick got=%b exp=000", tick); end
    checks++;
    if (div_clk !== 3'b000) begin errors++; $display("[TB] FAIL reset_div_clk got=%b exp=000", div_clk); end
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", cfg_ready); end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      et = '0; ed = '0;
      et[0] = (k % 2 == 0);
      et[1] = (k % 4 == 0);
      ed[0] = ((k / 2) % 2 == 1);
      ed[1] = ((k / 4) % 2 == 1);
      checks++;
      if (tick !== et) begin errors++; $display("[TB] FAIL startup_tick edge=%0d got=%b exp=%b", k, tick, et); end
      checks++;
      if (div_clk !== ed) begin errors++; $display("[TB] FAIL startup_div_clk edge=%0d got=%b exp=%b", k, div_clk, ed); end
    end
  endtask

  // Edge 8 left both counters at 0; write D=0 then D=2 to ch0
  task automatic test_reload();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL reload_ready_idle got=%b exp=1", cfg_ready); end
    step(); // edge 9: accepted, ch0 cnt 1
    cfg_div = 8'd2;
    #1;
    checks++;
    if (tick[0] !== 1'b0) begin errors++; $display("[TB] FAIL reload_tick_e9 got=%b exp=0", tick[0]); end
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL reload_ready_pending got=%b exp=0", cfg_ready); end
    step(); // edge 10: wrap with old D=1, D=0 becomes active
    checks++;
    if (tick[0] !== 1'b1) begin errors++; $display("[TB] FAIL reload_tick_e10 got=%b exp=1", tick[0]); end
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL reload_ready_after_wrap got=%b exp=1", cfg_ready); end
    step(); // edge 11: D=0 tick, held-off write of D=2 accepted
    cfg_valid = 1'b0;
    checks++;
    if (tick[0] !== 1'b1) begin errors++; $display("[TB] FAIL reload_tick_e11 got=%b exp=1", tick[0]); end
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL reload_ready_second got=%b exp=0", cfg_ready); end
    step(); // edge 12: D=0 tick, D=2 becomes active
    checks++;
    if (tick[0] !== 1'b1) begin errors++; $display("[TB] FAIL reload_tick_e12 got=%b exp=1", tick[0]); end
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL reload_ready_e12 got=%b exp=1", cfg_ready); end
    for (int k = 13; k <= 15; k++) begin
      step();
      checks++;
      if (tick[0] !== (k == 15)) begin errors++; $display("[TB] FAIL reload_period3 edge=%0d got=%b exp=%b", k, tick[0], (k == 15)); end
    end
  endtask

  // ch1 (D=3) wraps at 16, sits at cnt=2 after 18; ch0 (D=2) ticks on multiples of 3
  task automatic test_enable_hold();
    logic [NUM_CH-1:0] et;
    for (int k = 16; k <= 18; k++) begin
      step();
      et = '0;
      et[0] = (k % 3 == 0);
      et[1] = (k == 16);
      checks++;
      if (tick !== et) begin errors++; $display("[TB] FAIL hold_pre edge=%0d got=%b exp=%b", k, tick, et); end
    end
    en = 3'b001;
    for (int k = 19; k <= 23; k++) begin
      step();
      et = '0;
      et[0] = (k % 3 == 0);
      checks++;
      if (tick !== et) begin errors++; $display("[TB] FAIL hold_tick edge=%0d got=%b exp=%b", k, tick, et); end
      checks++;
      if (div_clk[1] !== 1'b0) begin errors++; $display("[TB] FAIL hold_div_clk edge=%0d got=%b exp=0", k, div_clk[1]); end
    end
    en = 3'b011;
    step(); // edge 24: ch1 2->3, ch0 wraps
    checks++;
    if (tick !== 3'b001) begin errors++; $display("[TB] FAIL resume_e24 got=%b exp=001", tick); end
    step(); // edge 25: ch1 wraps
    checks++;
    if (tick !== 3'b010) begin errors++; $display("[TB] FAIL resume_e25 got=%b exp=010", tick); end
    checks++;
    if (div_clk[1] !== 1'b1) begin errors++; $display("[TB] FAIL resume_div_clk got=%b exp=1", div_clk[1]); end
  endtask

  // Pending D=7 on ch1 is applied by sync; ch0 wrap at edge 27 is suppressed
  task automatic test_sync();
    logic [NUM_CH-1:0] et;
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd7;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL sync_ready_pre got=%b exp=1", cfg_ready); end
    step(); // edge 26
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL sync_ready_pending got=%b exp=0", cfg_ready); end
    sync = 1'b1;
    step(); // edge 27
    sync = 1'b0;
    checks++;
    if (tick !== 3'b000) begin errors++; $display("[TB] FAIL sync_tick got=%b exp=000", tick); end
    checks++;
    if (div_clk !== 3'b000) begin errors++; $display("[TB] FAIL sync_div_clk got=%b exp=000", div_clk); end
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL sync_ready_cleared got=%b exp=1", cfg_ready); end
    for (int k = 28; k <= 36; k++) begin
      step();
      et = '0;
      et[0] = ((k - 27) % 3 == 0);
      et[1] = (k == 35);
      checks++;
      if (tick !== et) begin errors++; $display("[TB] FAIL sync_after edge=%0d got=%b exp=%b", k, tick, et); end
    end
    checks++;
    if (div_clk !== 3'b011) begin errors++; $display("[TB] FAIL sync_div_clk_e36 got=%b exp=011", div_clk); end
  endtask

  task automatic test_out_of_range();
    logic [NUM_CH-1:0] et;
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd0;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL oor_ready got=%b exp=1", cfg_ready); end
    step(); // edge 37
    cfg_valid = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      cfg_ch = CH_W'(c);
      #1;
      checks++;
      if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL oor_no_pending ch=%0d got=%b exp=1", c, cfg_ready); end
    end
    checks++;
    if (tick !== 3'b000) begin errors++; $display("[TB] FAIL oor_tick_e37 got=%b exp=000", tick); end
    for (int k = 38; k <= 39; k++) begin
      step();
      et = '0;
      et[0] = (k == 39);
      checks++;
      if (tick !== et) begin errors++; $display("[TB] FAIL oor_after edge=%0d got=%b exp=%b", k, tick, et); end
    end
  endtask

  // Reset lands with a write pending on ch1; everything returns to DIV_INIT
  task automatic test_reset_mid();
    logic [NUM_CH-1:0] et;
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd2;
    step(); // edge 40
    cfg_valid = 1'b0;
    checks++;
    if (div_clk !== 3'b010) begin errors++; $display("[TB] FAIL rstmid_pre_div_clk got=%b exp=010", div_clk); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (div_clk !== 3'b000) begin errors++; $display("[TB] FAIL rstmid_async_div_clk got=%b exp=000", div_clk); end
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ready got=%b exp=1", cfg_ready); end
    step();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      et = '0;
      et[0] = (k % 2 == 0);
      et[1] = (k % 4 == 0);
      checks++;
      if (tick !== et) begin errors++; $display("[TB] FAIL rstmid_restart edge=%0d got=%b exp=%b", k, tick, et); end
    end
  endtask

  initial begin
    test_reset();
    test_reload();
    test_enable_hold();
    test_sync();
    test_out_of_range();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
